period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square-wave input in units of the system clock. It is the receiving end of the clock-divider path: it checks divided clocks, such as the divider's `clk_N` output, and external periodic inputs against their programmed ratio. Results go to the consumer through a valid/ready handshake, with sticky timeout and overrun flags.

---
 rtl/period_meter.sv | 142 ++++++++++++++
 tb/tb_period_meter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Results are offered through valid/ready, with sticky timeout and overrun flags.
module period_meter #(
    parameter int unsigned      CNT_W   = 32,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(1_000_000)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    input  logic             ready,
    output logic             timeout,
    output logic             overrun
);

    // state     | meaning
    // WAIT_EDGE | idle; first rising edge starts a measurement, no result
    // MEASURE   | counting edge-to-edge; each rising edge produces a result
    typedef enum logic {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             flush;
    logic             at_limit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic             do_start;
    logic             do_capture;
    logic             do_count;
    logic             do_timeout;

    assign flush    = !resetn || clr;
    assign rise     = s2 & ~s3;
    assign at_limit = (cnt == TIMEOUT);

    always_ff @(posedge clk) begin
        if (flush) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state <= WAIT_EDGE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_EDGE: if (rise) state_nxt = MEASURE;
            MEASURE:   if (!rise && at_limit) state_nxt = WAIT_EDGE;
            default:   state_nxt = WAIT_EDGE;
        endcase
    end

    always_comb begin
        do_start   = 1'b0;
        do_capture = 1'b0;
        do_count   = 1'b0;
        do_timeout = 1'b0;
        case (state)
            WAIT_EDGE: do_start = rise;
            MEASURE: begin
                if (rise) begin
                    do_capture = 1'b1;
                end else if (at_limit) begin
                    do_timeout = 1'b1;
                end else begin
                    do_count = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The edge cycle itself counts as one cycle of period and of high time.
    always_ff @(posedge clk) begin
        if (flush) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (do_start || do_capture) begin
            cnt  <= CNT_W'(1);
            hcnt <= CNT_W'(1);
        end else if (do_count) begin
            cnt  <= cnt + CNT_W'(1);
            hcnt <= hcnt + CNT_W'(s2);
        end
    end

    // clr leaves the last result visible; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            period    <= '0;
            high_time <= '0;
        end else if (!clr && do_capture) begin
            period    <= cnt;
            high_time <= hcnt;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (do_capture) begin
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (do_capture) begin
                timeout <= 1'b0;
            end else if (do_timeout) begin
                timeout <= 1'b1;
            end
            if (do_capture && valid && !ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: an edge-timestamp reference model is compared
// every cycle, plus literal expectations at the end of each scenario.
module tb_period_meter;

    localparam int TMO = 50;

    logic        clk;
    logic        resetn;
    logic        clr;
    logic        sig_in;
    logic        ready;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        valid;
    logic        timeout;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    period_meter #(
        .CNT_W  (32),
        .TIMEOUT(32'd50)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (clr),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .ready    (ready),
        .timeout  (timeout),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the cycle of the last detected edge and
    // accumulates synchronized-high samples since then.
    int cyc = 0;
    int last_rise = 0;
    int hi_acc = 0;
    bit meas = 0;
    bit ms1 = 0, ms2 = 0, ms3 = 0;
    bit ev = 0, et = 0, eo = 0;
    int ep = 0, eh = 0;

    always @(posedge clk) begin
        bit r;
        cyc++;
        if (!resetn || clr) begin
            ms1 = 0; ms2 = 0; ms3 = 0;
            meas = 0; ev = 0; et = 0; eo = 0;
            if (!resetn) begin
                ep = 0; eh = 0;
            end
        end else begin
            r = ms2 && !ms3;
            if (r && meas) begin
                if (ev && !ready) eo = 1;
                ep = cyc - last_rise;
                eh = hi_acc;
                ev = 1;
                et = 0;
            end else if (ev && ready) begin
                ev = 0;
            end
            if (r) begin
                meas = 1;
                last_rise = cyc;
                hi_acc = 1;
            end else if (meas) begin
                if (cyc - last_rise == TMO) begin
                    et = 1;
                    meas = 0;
                end else begin
                    hi_acc += int'(ms2);
                end
            end
            ms3 = ms2; ms2 = ms1; ms1 = sig_in;
        end
    end

    always @(negedge clk) begin
        chk("period",    period,    ep);
        chk("high_time", high_time, eh);
        chk("valid",     {31'd0, valid},   {31'd0, ev});
        chk("timeout",   {31'd0, timeout}, {31'd0, et});
        chk("overrun",   {31'd0, overrun}, {31'd0, eo});
    end

    int ph = 0;

    task automatic wave(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            sig_in = (ph < hi);
            ph = (ph + 1) % per;
        end
    endtask

    initial begin
        resetn = 1'b0; clr = 1'b0; sig_in = 1'b0; ready = 1'b1;
        wave(10, 0, 3);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_period",  period,    32'd0);
        chk("rst_high",    high_time, 32'd0);
        chk("rst_valid",   {31'd0, valid},   32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

        // divided clock, N=4
        ph = 0;
        wave(4, 2, 40);
        @(negedge clk);
        chk("div4_period", period,    32'd4);
        chk("div4_high",   high_time, 32'd2);

        ph = 0;
        wave(10, 3, 60);
        @(negedge clk);
        chk("p10_period",  period,    32'd10);
        chk("p10_high",    high_time, 32'd3);
        chk("p10_overrun", {31'd0, overrun}, 32'd0);

        ready = 1'b0;
        wave(10, 3, 25);
        @(negedge clk);
        chk("ovr_overrun", {31'd0, overrun}, 32'd1);
        chk("ovr_valid",   {31'd0, valid},   32'd1);
        chk("ovr_period",  period,    32'd10);
        ready = 1'b1;
        wave(10, 3, 5);

        ph = 0;
        wave(10, 3, 40);
        wave(10, 0, 70);
        @(negedge clk);
        chk("tmo_timeout", {31'd0, timeout}, 32'd1);
        chk("tmo_valid",   {31'd0, valid},   32'd0);
        ph = 0;
        wave(10, 3, 40);
        @(negedge clk);
        chk("tmo_cleared", {31'd0, timeout}, 32'd0);
        chk("tmo_period",  period,    32'd10);

        ready = 1'b0;
        ph = 0;
        wave(10, 3, 25);
        clr = 1'b1;
        wave(10, 3, 1);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_valid",   {31'd0, valid},   32'd0);
        chk("clr_timeout", {31'd0, timeout}, 32'd0);
        chk("clr_overrun", {31'd0, overrun}, 32'd0);
        chk("clr_period",  period,    32'd10);
        ready = 1'b1;
        wave(10, 3, 40);
        @(negedge clk);
        chk("clr_next_period", period,    32'd10);
        chk("clr_next_high",   high_time, 32'd3);

        ready = 1'b0;
        ph = 0;
        wave(10, 3, 25);
        resetn = 1'b0;
        wave(10, 3, 1);
        resetn = 1'b1;
        @(negedge clk);
        chk("mrst_period",  period,    32'd0);
        chk("mrst_high",    high_time, 32'd0);
        chk("mrst_valid",   {31'd0, valid},   32'd0);
        chk("mrst_overrun", {31'd0, overrun}, 32'd0);
        ready = 1'b1;
        wave(10, 3, 40);
        @(negedge clk);
        chk("mrst_next_period", period,    32'd10);
        chk("mrst_next_high",   high_time, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
